// File: rtl/bam_error_monitor.sv
// Windowed error statistics for the broken-array approximate multiplier: exact product,
// absolute error distance, counts and saturating ED sum. Define BAM_MAXERR_EN to track max ED.
module bam_error_monitor #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16,
    parameter int ACC_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               clear,
    input  logic [CNT_W-1:0]   num_samples,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2*WIDTH-1:0] p_approx,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   sample_cnt,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [ACC_W-1:0]   sum_ed,
    output logic [2*WIDTH-1:0] max_ed,
    output logic [WIDTH-1:0]   max_a,
    output logic [WIDTH-1:0]   max_b
);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic             ready_q, ready_d;
    logic             s1_valid_q, s1_valid_d;
    logic [PW-1:0]    s1_exact_q, s1_p_q;
    logic [CNT_W-1:0] sample_q, sample_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [ACC_W-1:0] sum_q, sum_d;

    logic             accept;
    logic             zero_stats;
    logic [PW-1:0]    ed;
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W-1:0] sum_sat;

    // Handshake: a sample transfers on a rising edge where in_valid && in_ready; in_ready
    // is registered from state and accepted count only, so it never depends on in_valid.
    assign accept     = in_valid && ready_q;
    assign zero_stats = clear || (start && (state_q == IDLE || state_q == DONE));

    assign ed      = (s1_exact_q >= s1_p_q) ? (s1_exact_q - s1_p_q) : (s1_p_q - s1_exact_q);
    assign sum_ext = {1'b0, sum_q} + {{(ACC_W + 1 - PW){1'b0}}, ed};
    assign sum_sat = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];

    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        acc_d      = acc_q;
        s1_valid_d = accept;
        sample_d   = sample_q;
        err_d      = err_q;
        sum_d      = sum_q;

        if (zero_stats) begin
            sample_d = '0;
            err_d    = '0;
            sum_d    = '0;
        end else if (s1_valid_q) begin
            sample_d = sample_q + CNT_W'(1);
            if (ed != '0) err_d = err_q + CNT_W'(1);
            sum_d = sum_sat;
        end

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    num_d   = num_samples;
                    acc_d   = '0;
                    state_d = (num_samples == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    acc_d = acc_q + CNT_W'(1);
                    if (acc_q + CNT_W'(1) == num_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Stats absorb stage 1 on the same edge it empties, so one idle cycle suffices.
                if (!s1_valid_q) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        if (clear) begin
            state_d    = IDLE;
            s1_valid_d = 1'b0;
            acc_d      = '0;
            num_d      = '0;
        end

        ready_d = (state_d == RUN) && (acc_d < num_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            num_q      <= '0;
            acc_q      <= '0;
            ready_q    <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_exact_q <= '0;
            s1_p_q     <= '0;
            sample_q   <= '0;
            err_q      <= '0;
            sum_q      <= '0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            acc_q      <= acc_d;
            ready_q    <= ready_d;
            s1_valid_q <= s1_valid_d;
            sample_q   <= sample_d;
            err_q      <= err_d;
            sum_q      <= sum_d;
            if (accept) begin
                s1_exact_q <= PW'(a) * PW'(b);
                s1_p_q     <= p_approx;
            end
        end
    end

`ifdef BAM_MAXERR_EN
    logic [WIDTH-1:0] s1_a_q, s1_b_q;
    logic [PW-1:0]    max_q, max_d;
    logic [WIDTH-1:0] max_a_q, max_a_d, max_b_q, max_b_d;

    // Strictly greater keeps the first operands seen on a tie.
    always_comb begin
        max_d   = max_q;
        max_a_d = max_a_q;
        max_b_d = max_b_q;
        if (zero_stats) begin
            max_d   = '0;
            max_a_d = '0;
            max_b_d = '0;
        end else if (s1_valid_q && (ed > max_q)) begin
            max_d   = ed;
            max_a_d = s1_a_q;
            max_b_d = s1_b_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_a_q  <= '0;
            s1_b_q  <= '0;
            max_q   <= '0;
            max_a_q <= '0;
            max_b_q <= '0;
        end else begin
            max_q   <= max_d;
            max_a_q <= max_a_d;
            max_b_q <= max_b_d;
            if (accept) begin
                s1_a_q <= a;
                s1_b_q <= b;
            end
        end
    end

    assign max_ed = max_q;
    assign max_a  = max_a_q;
    assign max_b  = max_b_q;
`else
    assign max_ed = '0;
    assign max_a  = '0;
    assign max_b  = '0;
`endif

    assign in_ready   = ready_q;
    assign busy       = (state_q == RUN) || (state_q == DRAIN);
    assign done       = (state_q == DONE);
    assign sample_cnt = sample_q;
    assign err_cnt    = err_q;
    assign sum_ed     = sum_q;

endmodule

// File: tb/tb_bam_error_monitor.sv
// Directed bench for bam_error_monitor: expected window results are queued at start and
// popped by a monitor whenever done rises; control corner cases are checked inline.
module tb_bam_error_monitor;
    localparam int WIDTH = 8;
    localparam int CNT_W = 16;
    localparam int ACC_W = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               clear = 1'b0;
    logic [CNT_W-1:0]   num_samples = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH-1:0]   a = '0;
    logic [WIDTH-1:0]   b = '0;
    logic [2*WIDTH-1:0] p_approx = '0;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   sample_cnt;
    logic [CNT_W-1:0]   err_cnt;
    logic [ACC_W-1:0]   sum_ed;
    logic [2*WIDTH-1:0] max_ed;
    logic [WIDTH-1:0]   max_a;
    logic [WIDTH-1:0]   max_b;

    int          total = 0;
    int          bad = 0;
    logic [79:0] exp_q[$];
    logic [79:0] snap;
    logic        done_d = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    bam_error_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .num_samples(num_samples), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .p_approx(p_approx), .busy(busy), .done(done),
        .sample_cnt(sample_cnt), .err_cnt(err_cnt), .sum_ed(sum_ed),
        .max_ed(max_ed), .max_a(max_a), .max_b(max_b)
    );

    assign snap = {sample_cnt, err_cnt, sum_ed, max_ed, max_a, max_b};

    function automatic logic [79:0] pack(input logic [15:0] sc, input logic [15:0] ec,
                                         input logic [15:0] se, input logic [15:0] me,
                                         input logic [7:0] ma, input logic [7:0] mb);
`ifdef BAM_MAXERR_EN
        return {sc, ec, se, me, ma, mb};
`else
        return {sc, ec, se, 16'd0, 8'd0, 8'd0};
`endif
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic [CNT_W-1:0] n);
        start = 1'b1;
        num_samples = n;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [15:0] tp);
        logic ok;
        a = ta;
        b = tb;
        p_approx = tp;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) return;
        end
        total++;
        bad++;
        $display("FAIL send_timeout: got no accept in 50 cycles, required accept");
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got done=0 after 20 cycles, required done=1");
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (done && !done_d) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL done_unexpected: got result %0h, required no window pending", snap);
            end else begin
                check("window_result", snap, exp_q.pop_front());
            end
        end
        done_d = done;
    end

    // ---------------- stimulus ----------------
    logic [31:0] bp_tab[4];
    int          acc;
    logic        r;

    initial begin
        bp_tab = '{{8'd10, 8'd10, 16'd100}, {8'd16, 8'd16, 16'd240},
                   {8'd7, 8'd9, 16'd70}, {8'd1, 8'd1, 16'd9}};

        repeat (3) @(posedge clk);
        #1;
        check("reset_stats", snap, '0);
        check("reset_ctl", {77'd0, in_ready, busy, done}, '0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("idle_ctl", {77'd0, in_ready, busy, done}, '0);
        end

        // exact window, back-to-back samples
        exp_q.push_back(pack(16'd2, 16'd1, 16'd1, 16'd1, 8'd255, 8'd255));
        do_start(16'd2);
        check("run_ready_busy", {78'd0, in_ready, busy}, 80'd3);
        send(8'd3, 8'd5, 16'd15);
        send(8'd255, 8'd255, 16'd65024);
        in_valid = 1'b0;
        check("drain_ctl", {77'd0, in_ready, busy, done}, 80'd2);
        @(posedge clk);
        #1 check("done_edge1", {79'd0, done}, 80'd0);
        @(posedge clk);
        #1 check("done_edge2", {79'd0, done}, 80'd1);

        // over-estimate gives absolute error
        exp_q.push_back(pack(16'd1, 16'd1, 16'd3, 16'd3, 8'd2, 8'd2));
        do_start(16'd1);
        send(8'd2, 8'd2, 16'd7);
        in_valid = 1'b0;
        wait_done();

        // asynchronous reset mid-cycle while holding results
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_stats", snap, '0);
        check("async_reset_ctl", {77'd0, in_ready, busy, done}, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // backpressure: valid held, only three accepted
        exp_q.push_back(pack(16'd3, 16'd2, 16'd23, 16'd16, 8'd16, 8'd16));
        do_start(16'd3);
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            {a, b, p_approx} = bp_tab[acc];
            in_valid = 1'b1;
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            if (r) begin
                acc++;
                if (acc == 3) check("ready_drop", {79'd0, in_ready}, 80'd0);
            end
        end
        in_valid = 1'b0;
        check("bp_accepts", acc, 80'd3);
        wait_done();

        // saturation of a 16-bit sum
        exp_q.push_back(pack(16'd2, 16'd2, 16'd65535, 16'd65025, 8'd255, 8'd255));
        do_start(16'd2);
        send(8'd255, 8'd255, 16'd0);
        send(8'd255, 8'd255, 16'd0);
        in_valid = 1'b0;
        wait_done();

        // start and clear together: clear wins
        start = 1'b1;
        clear = 1'b1;
        num_samples = 16'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        clear = 1'b0;
        check("start_clear_ctl", {77'd0, in_ready, busy, done}, '0);
        check("start_clear_stats", snap, '0);

        // start during RUN is ignored
        exp_q.push_back(pack(16'd3, 16'd2, 16'd6, 16'd5, 8'd5, 8'd5));
        do_start(16'd3);
        send(8'd3, 8'd3, 16'd8);
        in_valid = 1'b0;
        start = 1'b1;
        num_samples = 16'd1;
        @(posedge clk);
        #1 start = 1'b0;
        check("ignored_start_busy", {79'd0, busy}, 80'd1);
        check("ignored_start_cnt", sample_cnt, 80'd1);
        send(8'd4, 8'd4, 16'd16);
        send(8'd5, 8'd5, 16'd20);
        in_valid = 1'b0;
        wait_done();

        // clear mid-window discards in-flight sample
        do_start(16'd4);
        send(8'd9, 8'd9, 16'd0);
        in_valid = 1'b0;
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        check("clear_ctl", {77'd0, in_ready, busy, done}, '0);
        check("clear_stats", snap, '0);
        repeat (2) @(posedge clk);
        #1 check("clear_discard", snap, '0);

        // zero-length window
        exp_q.push_back(pack(16'd0, 16'd0, 16'd0, 16'd0, 8'd0, 8'd0));
        do_start(16'd0);
        check("zero_done", {78'd0, busy, done}, 80'd1);
        repeat (2) @(posedge clk);
        #1;

        // ---------------- final report ----------------
        check("queue_empty", exp_q.size(), 80'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
